// File: rtl/vr16_isa_pkg.sv
// VR16 ISA package: opcode values, instruction field helpers and the
// issue-stage FSM state encoding shared by the issue unit and its bench.
package vr16_isa_pkg;

    // Opcodes carried in instr[15:12]
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_DIVI  = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;
    localparam logic [3:0] OP_XOR   = 4'hB;
    localparam logic [3:0] OP_SHL   = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_NOT   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Instruction field positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 0;

    // Issue-stage sequencing
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } issue_state_e;

    function automatic logic [3:0] f_opcode(input logic [15:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] f_rd(input logic [15:0] w);
        return w[RD_HI:RD_LO];
    endfunction

    function automatic logic [3:0] f_rs1(input logic [15:0] w);
        return w[RS1_HI:RS1_LO];
    endfunction

    // rs2 and imm4 share the low nibble
    function automatic logic [3:0] f_rs2(input logic [15:0] w);
        return w[RS2_HI:RS2_LO];
    endfunction

    // Control-unit opcodes bypass the ALU writeback path
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_JUMP) || (op == OP_STORE) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/vr16_regfile.sv
// VR16 register file: 16 x 16-bit, two asynchronous operand read ports,
// one asynchronous debug read port and one synchronous write port.
// With R0_HARDWIRED != 0, r0 always reads zero and writes to it are dropped.
module vr16_regfile #(
    parameter int R0_HARDWIRED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rd_addr_a,
    output logic [15:0] rd_data_a,
    input  logic [3:0]  rd_addr_b,
    output logic [15:0] rd_data_b,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data
);

    localparam bit R0_ZERO = (R0_HARDWIRED != 0);

    logic [15:0] regs_q [16];
    logic        wr_fire;
    logic [3:0]  port_addr [3];
    logic [15:0] port_data [3];

    // Suppress writes to a hardwired r0
    always_comb begin
        wr_fire = wr_en && !(R0_ZERO && (wr_addr == 4'd0));
    end

    // Register storage; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign port_addr[0] = rd_addr_a;
    assign port_addr[1] = rd_addr_b;
    assign port_addr[2] = dbg_addr;

    // Identical read muxes for the two operand ports and the debug port
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
            assign port_data[gi] = (R0_ZERO && (port_addr[gi] == 4'd0)) ? 16'd0
                                                                         : regs_q[port_addr[gi]];
        end
    endgenerate

    assign rd_data_a = port_data[0];
    assign rd_data_b = port_data[1];
    assign dbg_data  = port_data[2];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: VR16 decode/issue stage. Accepts one instruction at a time,
// presents registered operands to the ALU, waits ALU_LATENCY cycles, then
// writes the ALU result back. Control opcodes are pulsed to the control unit.
// Optional feature macro: ISSUE_DIV0_TRAP_EN adds the div0_err port and
// traps division by zero with a writeback of 16'hFFFF.
module alu_issue_unit
    import vr16_isa_pkg::*;
#(
    parameter int ALU_LATENCY  = 1,
    parameter int R0_HARDWIRED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  alu_imm,
    output logic [15:0] alu_op_one,
    output logic [15:0] alu_op_two,
    input  logic [15:0] alu_result,
    output logic        ctrl_valid,
    output logic [3:0]  ctrl_opcode,
    output logic [3:0]  ctrl_rd,
    output logic [15:0] ctrl_data,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        busy,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
`ifdef ISSUE_DIV0_TRAP_EN
    ,
    output logic        div0_err
`endif
);

    // Wait counter only needs to hold ALU_LATENCY
    localparam int                CNT_W    = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ALU_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    issue_state_e     state_q, state_d;
    logic [3:0]       rd_q, rd_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic [3:0]       alu_imm_q, alu_imm_d;
    logic [15:0]      alu_op_one_q, alu_op_one_d;
    logic [15:0]      alu_op_two_q, alu_op_two_d;
    logic [15:0]      wb_data_q, wb_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic             div0_hit;
    logic             wr_en;
    logic [15:0]      rs1_data;
    logic [15:0]      rs2_data;

    assign accept = instr_valid && (state_q == ST_IDLE) && !reset;

    // Operands are read for the incoming word so they can be latched at accept
    vr16_regfile #(
        .R0_HARDWIRED (R0_HARDWIRED)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (f_rs1(instr)),
        .rd_data_a (rs1_data),
        .rd_addr_b (f_rs2(instr)),
        .rd_data_b (rs2_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (rd_q),
        .wr_data   (wb_data_q)
    );

`ifdef ISSUE_DIV0_TRAP_EN
    assign div0_hit = ((f_opcode(instr) == OP_DIV)  && (rs2_data == 16'd0)) ||
                      ((f_opcode(instr) == OP_DIVI) && (f_rs2(instr) == 4'd0));
`else
    assign div0_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (is_ctrl_op(alu_opcode_q)) begin
                    state_d = ST_IDLE;
                end else if (div0_q) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_WB;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; reset masks every pulse so an abandoned op signals nothing
    always_comb begin
        instr_ready = (state_q == ST_IDLE) && !reset;
        busy        = (state_q != ST_IDLE);
        wb_valid    = (state_q == ST_WB) && !reset;
        wr_en       = (state_q == ST_WB) && !reset;
        ctrl_valid  = (state_q == ST_ISSUE) && is_ctrl_op(alu_opcode_q) && !reset;
`ifdef ISSUE_DIV0_TRAP_EN
        div0_err    = (state_q == ST_WB) && div0_q && !reset;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q         <= '0;
            alu_opcode_q <= '0;
            alu_imm_q    <= '0;
            alu_op_one_q <= '0;
            alu_op_two_q <= '0;
            wb_data_q    <= '0;
            cnt_q        <= '0;
            div0_q       <= 1'b0;
        end else begin
            rd_q         <= rd_d;
            alu_opcode_q <= alu_opcode_d;
            alu_imm_q    <= alu_imm_d;
            alu_op_one_q <= alu_op_one_d;
            alu_op_two_q <= alu_op_two_d;
            wb_data_q    <= wb_data_d;
            cnt_q        <= cnt_d;
            div0_q       <= div0_d;
        end
    end

    // Datapath next values: latch on accept, arm the counter in ISSUE, capture in WAIT
    always_comb begin
        rd_d         = rd_q;
        alu_opcode_d = alu_opcode_q;
        alu_imm_d    = alu_imm_q;
        alu_op_one_d = alu_op_one_q;
        alu_op_two_d = alu_op_two_q;
        wb_data_d    = wb_data_q;
        cnt_d        = cnt_q;
        div0_d       = div0_q;

        if (accept) begin
            rd_d         = f_rd(instr);
            alu_opcode_d = f_opcode(instr);
            alu_imm_d    = f_rs2(instr);
            alu_op_one_d = rs1_data;
            alu_op_two_d = rs2_data;
            div0_d       = div0_hit;
        end

        case (state_q)
            ST_ISSUE: begin
                if (!is_ctrl_op(alu_opcode_q)) begin
                    if (div0_q) begin
                        wb_data_d = 16'hFFFF;
                    end else begin
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    wb_data_d = alu_result;
                end
            end
            default: begin
            end
        endcase
    end

    assign alu_opcode  = alu_opcode_q;
    assign alu_imm     = alu_imm_q;
    assign alu_op_one  = alu_op_one_q;
    assign alu_op_two  = alu_op_two_q;
    assign ctrl_opcode = alu_opcode_q;
    assign ctrl_rd     = rd_q;
    assign ctrl_data   = alu_op_one_q;
    assign wb_rd       = rd_q;
    assign wb_data     = wb_data_q;

endmodule
